// File: rtl/spi_command_controller.sv
// rtl/spi_command_controller.sv - SPI command decoder streaming RX FIFO frames to the host and collecting TX words
module spi_command_controller #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_cs,
  input  logic [7:0]            spi_rx_data,
  input  logic                  spi_rx_strobe,
  output logic [7:0]            spi_tx_data,
  input  logic                  rx_active,
  input  logic                  rx_error,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_empty,
  input  logic                  rx_full,
  output logic                  rx_read,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_push,
  input  logic                  tx_full,
  output logic                  soft_reset
);

  localparam int NB = (DATA_WIDTH + 2 + 7) / 8;
  localparam int FW = 8 * NB;
  localparam logic [2:0] LAST = 3'(NB - 1);

  typedef enum logic [2:0] {
    IDLE, STATUS, RX_FETCH, RX_SEND, TX_COLLECT, DISCARD
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        idx, idx_nxt;
  logic [FW-1:0]     frame, frame_nxt;
  logic [FW-1:0]     asm_word, asm_nxt, asm_shift;
  logic              sticky_rx_err, sticky_rx_err_nxt;
  logic              sticky_tx_ovf, sticky_tx_ovf_nxt;
  logic [7:0]        spi_tx_data_nxt;
  logic              rx_read_nxt, tx_push_nxt, soft_reset_nxt;
  logic [DATA_WIDTH-1:0] tx_data_nxt;
  logic [7:0]        status_byte;

  // Byte i of a frame, counted from the most significant end.
  function automatic logic [7:0] frame_byte(input logic [FW-1:0] f, input logic [2:0] i);
    logic [FW-1:0] sh;
    sh = f << (8 * int'(i));
    return sh[FW-1 -: 8];
  endfunction

  always_comb begin
    asm_shift   = FW'({asm_word, spi_rx_data});
    status_byte = {rx_active, rx_empty, rx_full, tx_full, sticky_rx_err, sticky_tx_ovf, 2'b00};
  end

  always_comb begin
    state_nxt         = state;
    idx_nxt           = idx;
    frame_nxt         = frame;
    asm_nxt           = asm_word;
    spi_tx_data_nxt   = spi_tx_data;
    rx_read_nxt       = 1'b0;
    tx_push_nxt       = 1'b0;
    soft_reset_nxt    = 1'b0;
    tx_data_nxt       = tx_data;
    sticky_rx_err_nxt = sticky_rx_err | rx_error;
    sticky_tx_ovf_nxt = sticky_tx_ovf;

    if (spi_cs) begin
      // Deselect abandons any partial word or unsent frame, including a strobe on the same cycle.
      state_nxt       = IDLE;
      idx_nxt         = 3'd0;
      spi_tx_data_nxt = 8'h00;
    end else begin
      case (state)
        IDLE: begin
          spi_tx_data_nxt = 8'h00;
          idx_nxt         = 3'd0;
          if (spi_rx_strobe) begin
            case (spi_rx_data)
              8'h01: state_nxt = STATUS;
              8'h04: state_nxt = TX_COLLECT;
              8'h05: begin
                state_nxt   = RX_FETCH;
                rx_read_nxt = !rx_empty;
              end
              8'h06: begin
                soft_reset_nxt = 1'b1;
                state_nxt      = DISCARD;
              end
              default: state_nxt = DISCARD;
            endcase
          end
        end
        RX_FETCH: begin
          // rx_read is high this cycle exactly when a word was available; the head is still valid.
          frame_nxt = '0;
          if (rx_read) frame_nxt[DATA_WIDTH-1:0] = rx_data;
          else         frame_nxt[FW-1] = 1'b1;
          frame_nxt[FW-2] = rx_error;
          spi_tx_data_nxt = frame_byte(frame_nxt, 3'd0);
          idx_nxt         = 3'd0;
          state_nxt       = RX_SEND;
        end
        RX_SEND: begin
          if (spi_rx_strobe) begin
            if (idx == LAST) begin
              idx_nxt     = 3'd0;
              state_nxt   = RX_FETCH;
              rx_read_nxt = !rx_empty;
            end else begin
              idx_nxt         = idx + 3'd1;
              spi_tx_data_nxt = frame_byte(frame, idx + 3'd1);
            end
          end
        end
        STATUS: begin
          spi_tx_data_nxt = status_byte;
          if (spi_rx_strobe) begin
            sticky_rx_err_nxt = rx_error;
            sticky_tx_ovf_nxt = 1'b0;
            spi_tx_data_nxt   = 8'h00;
            state_nxt         = DISCARD;
          end
        end
        TX_COLLECT: begin
          spi_tx_data_nxt = 8'h00;
          if (spi_rx_strobe) begin
            asm_nxt = asm_shift;
            if (idx == LAST) begin
              idx_nxt     = 3'd0;
              tx_data_nxt = asm_shift[DATA_WIDTH-1:0];
              if (!tx_full) tx_push_nxt       = 1'b1;
              else          sticky_tx_ovf_nxt = 1'b1;
            end else begin
              idx_nxt = idx + 3'd1;
            end
          end
        end
        default: spi_tx_data_nxt = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      idx           <= 3'd0;
      frame         <= '0;
      asm_word      <= '0;
      sticky_rx_err <= 1'b0;
      sticky_tx_ovf <= 1'b0;
      spi_tx_data   <= 8'h00;
      rx_read       <= 1'b0;
      tx_push       <= 1'b0;
      tx_data       <= '0;
      soft_reset    <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      frame         <= frame_nxt;
      asm_word      <= asm_nxt;
      sticky_rx_err <= sticky_rx_err_nxt;
      sticky_tx_ovf <= sticky_tx_ovf_nxt;
      spi_tx_data   <= spi_tx_data_nxt;
      rx_read       <= rx_read_nxt;
      tx_push       <= tx_push_nxt;
      tx_data       <= tx_data_nxt;
      soft_reset    <= soft_reset_nxt;
    end
  end

endmodule

// File: tb/tb_spi_command_controller.sv
// tb/tb_spi_command_controller.sv - scoreboard bench for spi_command_controller at DATA_WIDTH 10 and 16
module tb_spi_command_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst10, rst16, spi_cs;
  logic [7:0] spi_rx_data;
  logic       strobe10, strobe16;
  logic       rx_active, rx_error, rx_full, tx_full;

  logic [7:0]  tx10, tx16;
  logic        rd10, rd16, push10, push16, sr10, sr16;
  logic [9:0]  txd10;
  logic [15:0] txd16;

  logic [9:0]  mem10 [8];
  logic [15:0] mem16 [8];
  logic [2:0]  rp10 = 3'd0, wp10 = 3'd0, rp16 = 3'd0, wp16 = 3'd0;
  logic        empty10, empty16;
  logic [9:0]  rxd10;
  logic [15:0] rxd16;

  assign empty10 = (rp10 == wp10);
  assign empty16 = (rp16 == wp16);
  assign rxd10   = mem10[rp10];
  assign rxd16   = mem16[rp16];

  always @(posedge clk) begin
    if (rd10) rp10 <= rp10 + 3'd1;
    if (rd16) rp16 <= rp16 + 3'd1;
  end

  spi_command_controller #(.DATA_WIDTH(10)) dut10 (
    .clk(clk), .reset_n(rst10), .spi_cs(spi_cs), .spi_rx_data(spi_rx_data),
    .spi_rx_strobe(strobe10), .spi_tx_data(tx10), .rx_active(rx_active), .rx_error(rx_error),
    .rx_data(rxd10), .rx_empty(empty10), .rx_full(rx_full), .rx_read(rd10),
    .tx_data(txd10), .tx_push(push10), .tx_full(tx_full), .soft_reset(sr10));

  spi_command_controller #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .reset_n(rst16), .spi_cs(spi_cs), .spi_rx_data(spi_rx_data),
    .spi_rx_strobe(strobe16), .spi_tx_data(tx16), .rx_active(rx_active), .rx_error(rx_error),
    .rx_data(rxd16), .rx_empty(empty16), .rx_full(rx_full), .rx_read(rd16),
    .tx_data(txd16), .tx_push(push16), .tx_full(tx_full), .soft_reset(sr16));

  int total = 0;
  int bad = 0;
  int rdcnt10 = 0, rdcnt16 = 0, pushcnt = 0, srcnt = 0;
  logic [7:0] exp_bytes [$];
  logic [9:0] exp_push [$];
  logic       chk_byte = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  task automatic missing(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s act=0x%0h exp=none", name, act);
  endtask

  // Monitor: compares every presented output against the scoreboard queues.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if ((strobe10 || strobe16) && chk_byte) begin
        b = strobe10 ? tx10 : tx16;
        if (exp_bytes.size() == 0) missing("spi_tx_data", 32'(b));
        else check("spi_tx_data", 32'(b), 32'(exp_bytes.pop_front()));
      end
      if (push10) begin
        pushcnt++;
        if (exp_push.size() == 0) missing("tx_data", 32'(txd10));
        else check("tx_data", 32'(txd10), 32'(exp_push.pop_front()));
      end
      if (push16) missing("tx_push16", 32'(txd16));
      if (rd10) begin
        rdcnt10++;
        check("rx_read_on_nonempty10", 32'(empty10), 32'd0);
      end
      if (rd16) begin
        rdcnt16++;
        check("rx_read_on_nonempty16", 32'(empty16), 32'd0);
      end
      if (sr10) srcnt++;
    end
  end

  task automatic send(input logic sel16, input logic [7:0] b, input logic chk, input logic [7:0] exp);
    @(posedge clk); #1;
    spi_rx_data = b;
    if (chk) exp_bytes.push_back(exp);
    chk_byte = chk;
    if (sel16) strobe16 = 1'b1; else strobe10 = 1'b1;
    @(posedge clk); #1;
    strobe10 = 1'b0;
    strobe16 = 1'b0;
    chk_byte = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic cs_begin();
    @(posedge clk); #1 spi_cs = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic cs_end();
    @(posedge clk); #1 spi_cs = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  typedef struct { logic [7:0] cmd; logic [7:0] b [4]; } vec_t;

  initial begin
    int r0, p0, s0;
    logic [7:0] frame_exp [6];
    rst10 = 1'b0; rst16 = 1'b0; spi_cs = 1'b1; spi_rx_data = 8'h00;
    strobe10 = 1'b0; strobe16 = 1'b0;
    rx_active = 1'b0; rx_error = 1'b0; rx_full = 1'b0; tx_full = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_spi_tx_data10", 32'(tx10), 32'h0);
    check("reset_rx_read10", 32'(rd10), 32'h0);
    check("reset_tx_data10", 32'(txd10), 32'h0);
    check("reset_tx_push10", 32'(push10), 32'h0);
    check("reset_soft_reset10", 32'(sr10), 32'h0);
    check("reset_spi_tx_data16", 32'(tx16), 32'h0);
    check("reset_rx_read16", 32'(rd16), 32'h0);
    rst10 = 1'b1; rst16 = 1'b1;
    repeat (2) @(posedge clk);

    // RX frames: two words then an empty frame.
    mem10[0] = 10'h2A5; mem10[1] = 10'h001; wp10 = 3'd2;
    frame_exp = '{8'h02, 8'hA5, 8'h00, 8'h01, 8'h80, 8'h00};
    r0 = rdcnt10;
    cs_begin();
    send(1'b0, 8'h05, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) send(1'b0, 8'h00, 1'b1, frame_exp[i]);
    cs_end();
    check("rx_read_count_frames", 32'(rdcnt10 - r0), 32'd2);

    // RX with rx_error during the first capture.
    mem10[2] = 10'h2A5; mem10[3] = 10'h001; wp10 = 3'd4;
    frame_exp = '{8'h42, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h00};
    r0 = rdcnt10;
    rx_error = 1'b1;
    cs_begin();
    send(1'b0, 8'h05, 1'b0, 8'h00);
    rx_error = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 8'h00, 1'b1, frame_exp[i]);
    cs_end();
    check("rx_read_count_err", 32'(rdcnt10 - r0), 32'd2);

    // TX words, then the same words against a full TX FIFO.
    p0 = pushcnt;
    exp_push.push_back(10'h123);
    exp_push.push_back(10'h3FF);
    cs_begin();
    send(1'b0, 8'h04, 1'b0, 8'h00);
    send(1'b0, 8'h01, 1'b0, 8'h00); send(1'b0, 8'h23, 1'b0, 8'h00);
    send(1'b0, 8'h03, 1'b0, 8'h00); send(1'b0, 8'hFF, 1'b0, 8'h00);
    cs_end();
    check("tx_push_count", 32'(pushcnt - p0), 32'd2);
    p0 = pushcnt;
    tx_full = 1'b1;
    cs_begin();
    send(1'b0, 8'h04, 1'b0, 8'h00);
    send(1'b0, 8'h01, 1'b0, 8'h00); send(1'b0, 8'h23, 1'b0, 8'h00);
    send(1'b0, 8'h03, 1'b0, 8'h00); send(1'b0, 8'hFF, 1'b0, 8'h00);
    cs_end();
    tx_full = 1'b0;
    check("tx_push_count_full", 32'(pushcnt - p0), 32'd0);

    // Status: sticky rx_error and tx_overflow set, rx_empty=1; second read sees them cleared.
    cs_begin();
    send(1'b0, 8'h01, 1'b0, 8'h00);
    send(1'b0, 8'h00, 1'b1, 8'h4C);
    cs_end();
    cs_begin();
    send(1'b0, 8'h01, 1'b0, 8'h00);
    send(1'b0, 8'h00, 1'b1, 8'h40);
    cs_end();

    // Partial TX word abandoned by deselect.
    p0 = pushcnt;
    exp_push.push_back(10'h007);
    cs_begin();
    send(1'b0, 8'h04, 1'b0, 8'h00);
    send(1'b0, 8'h55, 1'b0, 8'h00);
    cs_end();
    cs_begin();
    send(1'b0, 8'h04, 1'b0, 8'h00);
    send(1'b0, 8'h00, 1'b0, 8'h00); send(1'b0, 8'h07, 1'b0, 8'h00);
    cs_end();
    check("tx_push_count_partial", 32'(pushcnt - p0), 32'd1);

    // Soft reset, then an unknown command followed by 20 ignored strobes.
    s0 = srcnt;
    cs_begin();
    send(1'b0, 8'h06, 1'b0, 8'h00);
    cs_end();
    check("soft_reset_count", 32'(srcnt - s0), 32'd1);
    s0 = srcnt; p0 = pushcnt; r0 = rdcnt10;
    cs_begin();
    send(1'b0, 8'h7E, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) send(1'b0, 8'(8'h05 + i), 1'b1, 8'h00);
    cs_end();
    check("unknown_soft_reset", 32'(srcnt - s0), 32'd0);
    check("unknown_push", 32'(pushcnt - p0), 32'd0);
    check("unknown_read", 32'(rdcnt10 - r0), 32'd0);
    check("unknown_tx_data_hold", 32'(txd10), 32'h007);

    // DATA_WIDTH=16: reset mid-frame, then framing restarts at byte 0.
    mem16[0] = 16'hBEEF; wp16 = 3'd1;
    cs_begin();
    send(1'b1, 8'h05, 1'b0, 8'h00);
    send(1'b1, 8'h00, 1'b1, 8'h00);
    send(1'b1, 8'h00, 1'b1, 8'hBE);
    @(posedge clk); #1 rst16 = 1'b0;
    #1;
    check("async_reset_spi_tx_data16", 32'(tx16), 32'h0);
    check("async_reset_rx_read16", 32'(rd16), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst16 = 1'b1;
    cs_end();
    mem16[1] = 16'h1234; wp16 = 3'd2;
    cs_begin();
    send(1'b1, 8'h05, 1'b0, 8'h00);
    send(1'b1, 8'h00, 1'b1, 8'h00);
    send(1'b1, 8'h00, 1'b1, 8'h12);
    send(1'b1, 8'h00, 1'b1, 8'h34);
    cs_end();
    check("rx_read_count16", 32'(rdcnt16), 32'd2);

    repeat (5) @(posedge clk);
    check("byte_queue_drained", 32'(exp_bytes.size()), 32'd0);
    check("push_queue_drained", 32'(exp_push.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
